// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV32E decode pipeline stage with operand read, bypass and skid buffer
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int BYPASS_EN = 1,
  parameter int SKID_EN = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic            out_illegal
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic            ill;
  } entry_t;

  entry_t d, o, s;
  logic skid_full, known, u_rd, u1, u2;
  logic accept, load_out, cap;

  function automatic logic [XLEN-1:0] sel(input logic [4:0] rs, input logic [XLEN-1:0] rf_val);
    return rs == 5'd0 ? '0 : (BYPASS_EN != 0 && wb_en && wb_rd == rs) ? wb_data : rf_val;
  endfunction

  function automatic entry_t fresh(input entry_t e);
    entry_t r;
    r = e;
    if (BYPASS_EN != 0 && wb_en && e.instr[19:15] != 5'd0 && wb_rd == e.instr[19:15]) r.v1 = wb_data;
    if (BYPASS_EN != 0 && wb_en && e.instr[24:20] != 5'd0 && wb_rd == e.instr[24:20]) r.v2 = wb_data;
    return r;
  endfunction

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];
  assign load_out  = !out_valid || out_ready;
  assign in_ready  = SKID_EN != 0 ? !skid_full : load_out;
  assign accept    = in_valid && in_ready;
  assign cap       = SKID_EN != 0 && accept && out_valid && !out_ready;

  // Decode the incoming word: immediate, register usage, legality and operands
  always_comb begin
    d.instr = in_instr;
    d.pc = in_pc;
    d.imm = '0;
    known = 1'b1;
    u_rd = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin d.imm = XLEN'($signed({in_instr[31:12], 12'b0})); u_rd = 1'b1; end
      7'b1101111: begin d.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})); u_rd = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0010011: begin d.imm = XLEN'($signed(in_instr[31:20])); u_rd = 1'b1; u1 = 1'b1; end
      7'b1100011: begin d.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0})); u1 = 1'b1; u2 = 1'b1; end
      7'b0100011: begin d.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]})); u1 = 1'b1; u2 = 1'b1; end
      7'b0110011: begin u_rd = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      7'b1110011, 7'b0001111: begin u_rd = 1'b1; u1 = 1'b1; end
      default: known = 1'b0;
    endcase
    d.ill = in_instr[1:0] != 2'b11 || !known ||
            (NREG == 16 && ((u_rd && in_instr[11]) || (u1 && in_instr[19]) || (u2 && in_instr[24])));
    d.v1 = sel(in_instr[19:15], rf_rdata1);
    d.v2 = sel(in_instr[24:20], rf_rdata2);
  end

  // Output register and skid entry; flush wins over accept/consume, held operands track writeback
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o <= '0;
      s <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      o <= load_out ? (skid_full ? fresh(s) : d) : fresh(o);
      s <= cap ? d : fresh(s);
      out_valid <= !flush && (load_out ? (skid_full || accept) : 1'b1);
      skid_full <= !flush && (cap || (skid_full && !load_out));
    end
  end

  assign out_pc      = o.pc;
  assign out_opcode  = o.instr[6:0];
  assign out_rd      = o.instr[11:7];
  assign out_rs1     = o.instr[19:15];
  assign out_rs2     = o.instr[24:20];
  assign out_funct3  = o.instr[14:12];
  assign out_funct7  = o.instr[31:25];
  assign out_imm     = o.imm;
  assign out_rs1_val = o.v1;
  assign out_rs2_val = o.v2;
  assign out_illegal = o.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven scoreboard bench for decode_stage (RV32I and RV32E instances)
module tb_decode_stage;
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, wb_en = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_data = '0;
  logic [4:0] wb_rd = '0;
  logic in_ready, out_valid, out_illegal;
  logic [4:0] rf_raddr1, rf_raddr2, out_rd, out_rs1, out_rs2;
  logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic e_in_ready, e_out_valid, e_out_illegal;
  logic [4:0] e_rf_raddr1, e_rf_raddr2, e_out_rd, e_out_rs1, e_out_rs2;
  logic [31:0] e_out_pc, e_out_imm, e_out_rs1_val, e_out_rs2_val;
  logic [6:0] e_out_opcode, e_out_funct7;
  logic [2:0] e_out_funct3;

  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, imm;
    logic        ill, ill_e;
    logic [31:0] v1, v2;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[11];
  vec_t bp[4];
  vec_t ev, rv;
  int checks = 0, errors = 0;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_illegal(out_illegal));

  decode_stage #(.XLEN(32), .NREG(16)) dut_e (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(e_rf_raddr1), .rf_raddr2(e_rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc), .out_opcode(e_out_opcode),
    .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_funct3(e_out_funct3),
    .out_funct7(e_out_funct7), .out_imm(e_out_imm), .out_rs1_val(e_out_rs1_val),
    .out_rs2_val(e_out_rs2_val), .out_illegal(e_out_illegal));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every output consumed is compared against the oldest accepted instruction
  always @(negedge clk) begin
    if (resetn && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
      end else begin
        ev = sb.pop_front();
        chk("pc", 64'(out_pc), 64'(ev.pc));
        chk("opcode", 64'(out_opcode), 64'(ev.instr[6:0]));
        chk("rd", 64'(out_rd), 64'(ev.instr[11:7]));
        chk("rs1", 64'(out_rs1), 64'(ev.instr[19:15]));
        chk("rs2", 64'(out_rs2), 64'(ev.instr[24:20]));
        chk("funct3", 64'(out_funct3), 64'(ev.instr[14:12]));
        chk("funct7", 64'(out_funct7), 64'(ev.instr[31:25]));
        chk("imm", 64'(out_imm), 64'(ev.imm));
        chk("illegal", 64'(out_illegal), 64'(ev.ill));
        chk("rs1_val", 64'(out_rs1_val), 64'(ev.v1));
        chk("rs2_val", 64'(out_rs2_val), 64'(ev.v2));
        chk("illegal_rv32e", 64'(e_out_illegal), 64'(ev.ill_e));
      end
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    logic ok = 1'b0;
    in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc; rf_rdata1 = v.r1; rf_rdata2 = v.r2;
    wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    #1;
    chk("rf_raddr1", 64'(rf_raddr1), 64'(v.instr[19:15]));
    chk("rf_raddr2", 64'(rf_raddr2), 64'(v.instr[24:20]));
    while (!ok && n < 50) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    if (ok) sb.push_back(v);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept for pc %h expected accept", v.pc);
    end
    in_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          instr          pc       r1     r2    wb  rd  wb_data  imm           ill   ill_e v1     v2
    tbl[0]  = '{32'hFFF00093, 32'h100, 32'h55, 32'h66, 0, 0, 32'h0,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,  32'h66};
    tbl[1]  = '{32'h800000EF, 32'h104, 32'h55, 32'h66, 0, 0, 32'h0,  32'hFFF00000, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[2]  = '{32'hFE000EE3, 32'h108, 32'h55, 32'h66, 0, 0, 32'h0,  32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[3]  = '{32'h00428313, 32'h10C, 32'h11, 32'h77, 1, 5, 32'h22, 32'h4,        1'b0, 1'b0, 32'h22, 32'h77};
    tbl[4]  = '{32'h00400313, 32'h110, 32'h11, 32'h77, 1, 0, 32'h22, 32'h4,        1'b0, 1'b0, 32'h0,  32'h77};
    tbl[5]  = '{32'h002088B3, 32'h114, 32'hA,  32'hB,  0, 0, 32'h0,  32'h0,        1'b0, 1'b1, 32'hA,  32'hB};
    tbl[6]  = '{32'h00000000, 32'h118, 32'h55, 32'h66, 0, 0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h0,  32'h0};
    tbl[7]  = '{32'h12345537, 32'h11C, 32'h1,  32'h2,  0, 0, 32'h0,  32'h12345000, 1'b0, 1'b0, 32'h1,  32'h2};
    tbl[8]  = '{32'hFE20AC23, 32'h120, 32'h3,  32'h4,  0, 0, 32'h0,  32'hFFFFFFF8, 1'b0, 1'b0, 32'h3,  32'h4};
    tbl[9]  = '{32'h0000007F, 32'h124, 32'h55, 32'h66, 0, 0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h0,  32'h0};
    tbl[10] = '{32'h00080093, 32'h128, 32'h9,  32'h66, 0, 0, 32'h0,  32'h0,        1'b0, 1'b1, 32'h9,  32'h0};
    for (int i = 0; i < 4; i++)
      bp[i] = '{((i + 1) << 20) | ((i + 1) << 7) | 32'h13, 32'h200 + 4 * i, 32'h0, 32'h0, 0, 0, 32'h0,
                32'(i + 1), 1'b0, 1'b0, 32'h0, 32'h0};
    rv = '{32'h007001B3, 32'h300, 32'h99, 32'h5, 0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hABCD};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_imm", 64'(out_imm), 64'd0);
    chk("reset_illegal", 64'(out_illegal), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) send(tbl[i]);
    drain();

    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_pc", 64'(out_pc), 64'(bp[0].pc));
    fork
      begin send(bp[2]); send(bp[3]); end
      begin
        @(negedge clk);
        chk("bp_in_ready_stall", 64'(in_ready), 64'd0);
        chk("bp_held", 64'(sb.size()), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(rv);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hABCD;
    @(negedge clk);
    chk("refresh_before", 64'(out_rs2_val), 64'h5);
    @(posedge clk); #1;
    wb_en = 1'b0;
    chk("refresh_after", 64'(out_rs2_val), 64'hABCD);
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    in_valid = 1'b1; in_instr = bp[2].instr; in_pc = bp[2].pc; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_quiet", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    send(tbl[1]);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_reset_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_pc", 64'(out_pc), 64'd0);
    chk("mid_reset_imm", 64'(out_imm), 64'd0);
    chk("mid_reset_rd", 64'(out_rd), 64'd0);
    chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
